// File: rtl/agent_req_port.sv
// In-order read master for one system_agent requester slot: tags requests, reorders completions by tag.
// Request strobe 1 cycle after accept, rsp_valid 1 cycle after head completion; req_ready low while DEPTH are outstanding.
module agent_req_port #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        err_unexp,
    output logic [15:0] ip_addr,
    output logic [5:0]  ip_req_trans,
    input  logic [31:0] ip_dat,
    input  logic [3:0]  ip_trans_id
);

    typedef enum logic [1:0] {FREE, PEND, DONE} slot_state_t;

    localparam logic [3:0] DEPTH_W = 4'(DEPTH);
    localparam logic [3:0] LAST    = 4'(DEPTH - 1);

    // Arrays span the whole 4-bit tag space so every index is full width;
    // entries at DEPTH and above are never written and stay FREE.
    slot_state_t state [16];
    logic [31:0] data  [16];

    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] count;
    logic [3:0] cpl_idx;
    logic       accept;
    logic       retire;
    logic       cpl_hit;
    logic       cpl_bad;

    assign req_ready = (count < DEPTH_W);
    assign rsp_valid = (state[rd_ptr] == DONE);
    assign rsp_data  = data[rd_ptr];
    assign accept    = req_valid && req_ready;
    assign retire    = rsp_valid && rsp_ready;
    assign cpl_idx   = ip_trans_id - 4'd1;

    always_comb begin
        cpl_hit = 1'b0;
        cpl_bad = 1'b0;
        if (ip_trans_id != 4'd0) begin
            if ((ip_trans_id <= DEPTH_W) && (state[cpl_idx] == PEND)) begin
                cpl_hit = 1'b1;
            end else begin
                cpl_bad = 1'b1;
            end
        end
    end

    // Retire, accept and completion always touch distinct slots, so the
    // three indexed writes below never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                state[i] <= FREE;
                data[i]  <= 32'd0;
            end
            wr_ptr       <= 4'd0;
            rd_ptr       <= 4'd0;
            count        <= 4'd0;
            err_unexp    <= 1'b0;
            ip_addr      <= 16'd0;
            ip_req_trans <= 6'd0;
        end else begin
            if (retire) begin
                state[rd_ptr] <= FREE;
                rd_ptr        <= (rd_ptr == LAST) ? 4'd0 : rd_ptr + 4'd1;
            end

            if (accept) begin
                state[wr_ptr] <= PEND;
                ip_addr       <= req_addr;
                ip_req_trans  <= {1'b1, 1'b0, wr_ptr + 4'd1};
                wr_ptr        <= (wr_ptr == LAST) ? 4'd0 : wr_ptr + 4'd1;
            end else begin
                ip_req_trans  <= 6'd0;
            end

            if (cpl_hit) begin
                state[cpl_idx] <= DONE;
                data[cpl_idx]  <= ip_dat;
            end
            if (cpl_bad) begin
                err_unexp <= 1'b1;
            end

            case ({accept, retire})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_agent_req_port.sv
// Directed bench for agent_req_port: queue-based reference model checked every cycle plus literal spot checks.
module tb_agent_req_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        err_unexp;
    logic [15:0] ip_addr;
    logic [5:0]  ip_req_trans;
    logic [31:0] ip_dat = 32'd0;
    logic [3:0]  ip_trans_id = 4'd0;

    int nvec = 0;
    int nerr = 0;

    agent_req_port #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .err_unexp    (err_unexp),
        .ip_addr      (ip_addr),
        .ip_req_trans (ip_req_trans),
        .ip_dat       (ip_dat),
        .ip_trans_id  (ip_trans_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered queue of outstanding tags, per-tag done flag and data.
    int          q[$];
    bit          inq   [16];
    bit          mdone [16];
    logic [31:0] mdat  [16];
    int          mtag    = 1;
    logic        m_err   = 1'b0;
    logic [5:0]  m_trans = 6'd0;
    logic [15:0] m_addr  = 16'd0;

    initial begin
        foreach (inq[i]) begin inq[i] = 1'b0; mdone[i] = 1'b0; mdat[i] = 32'd0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                foreach (inq[i]) begin inq[i] = 1'b0; mdone[i] = 1'b0; end
                mtag = 1; m_err = 1'b0; m_trans = 6'd0; m_addr = 16'd0;
            end else begin
                bit acc;
                bit ret;
                int id;
                acc = req_valid && (q.size() < DEPTH);
                ret = rsp_ready && (q.size() > 0) && mdone[q[0]];
                id  = int'(ip_trans_id);
                if (id != 0) begin
                    if (id <= DEPTH && inq[id] && !mdone[id]) begin
                        mdone[id] = 1'b1;
                        mdat[id]  = ip_dat;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (ret) begin
                    inq[q[0]]   = 1'b0;
                    mdone[q[0]] = 1'b0;
                    void'(q.pop_front());
                end
                if (acc) begin
                    q.push_back(mtag);
                    inq[mtag] = 1'b1;
                    m_trans   = {2'b10, 4'(mtag)};
                    m_addr    = req_addr;
                    mtag      = (mtag == DEPTH) ? 1 : mtag + 1;
                end else begin
                    m_trans = 6'd0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (q.size() > 0) && mdone[q[0]];
        chk("m_req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) chk("m_rsp_data", rsp_data, mdat[q[0]]);
        chk("m_err_unexp", 32'(err_unexp), 32'(m_err));
        chk("m_ip_req_trans", 32'(ip_req_trans), 32'(m_trans));
        chk("m_ip_addr", 32'(ip_addr), 32'(m_addr));
    end

    task automatic tick(input logic v, input logic [15:0] a, input logic [3:0] id,
                        input logic [31:0] d, input logic rr);
        req_valid   = v;
        req_addr    = a;
        ip_trans_id = id;
        ip_dat      = d;
        rsp_ready   = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; ip_trans_id = 4'd0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_err", 32'(err_unexp), 32'd0);
        chk("rst_trans", 32'(ip_req_trans), 32'd0);
        chk("rst_addr", 32'(ip_addr), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t;
        rst_n = 1'b0;
        do_reset();

        // Single read
        tick(1'b1, 16'h0040, 4'd0, 32'd0, 1'b0);
        chk("single_trans", 32'(ip_req_trans), 32'h21);
        chk("single_addr", 32'(ip_addr), 32'h0040);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b0);
        chk("single_strobe_off", 32'(ip_req_trans), 32'h0);
        chk("single_addr_hold", 32'(ip_addr), 32'h0040);
        tick(1'b0, 16'h0000, 4'd1, 32'hDEADBEEF, 1'b0);
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data", rsp_data, 32'hDEADBEEF);
        chk("single_no_err", 32'(err_unexp), 32'd0);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        chk("single_retired", 32'(rsp_valid), 32'd0);

        // Fill from a clean start, then out-of-order completion
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 16'h1000 + 16'(i), 4'd0, 32'd0, 1'b1);
            chk("fill_tag", 32'(ip_req_trans), 32'h20 + 32'(i + 1));
        end
        chk("fill_full", 32'(req_ready), 32'd0);
        tick(1'b1, 16'h2000, 4'd3, 32'h33, 1'b1);
        chk("full_no_accept", 32'(ip_req_trans), 32'd0);
        chk("ooo_wait_head", 32'(rsp_valid), 32'd0);
        tick(1'b0, 16'h0000, 4'd1, 32'h11, 1'b1);
        chk("ooo_head_valid", 32'(rsp_valid), 32'd1);
        chk("ooo_d11", rsp_data, 32'h11);
        chk("ooo_still_full", 32'(req_ready), 32'd0);
        tick(1'b0, 16'h0000, 4'd4, 32'h44, 1'b1);
        chk("ooo_gap", 32'(rsp_valid), 32'd0);
        chk("ooo_ready_back", 32'(req_ready), 32'd1);
        tick(1'b0, 16'h0000, 4'd2, 32'h22, 1'b1);
        chk("ooo_d22", rsp_data, 32'h22);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        chk("ooo_d33", rsp_data, 32'h33);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        chk("ooo_d44", rsp_data, 32'h44);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        chk("ooo_drained", 32'(rsp_valid), 32'd0);

        // Backpressure
        tick(1'b1, 16'h0300, 4'd0, 32'd0, 1'b0);
        chk("bp_tag", 32'(ip_req_trans), 32'h21);
        tick(1'b0, 16'h0000, 4'd1, 32'hA5A5A5A5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_stable", rsp_data, 32'hA5A5A5A5);
        end
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        chk("bp_retired", 32'(rsp_valid), 32'd0);

        // Ten sequential reads across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            t = 4'(((i + 1) % 4) + 1);
            tick(1'b1, 16'h0400 + 16'(i), 4'd0, 32'd0, 1'b0);
            chk("wrap_tag", 32'(ip_req_trans), {26'd0, 2'b10, t});
            tick(1'b0, 16'h0000, t, 32'hC0DE0000 + 32'(i), 1'b0);
            chk("wrap_data", rsp_data, 32'hC0DE0000 + 32'(i));
            tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);
        end

        // Unexpected completions while one read is pending
        tick(1'b1, 16'h0500, 4'd0, 32'd0, 1'b0);
        chk("bad_pre_tag", 32'(ip_req_trans), 32'h24);
        tick(1'b0, 16'h0000, 4'd7, 32'h00000BAD, 1'b0);
        chk("bad_err_7", 32'(err_unexp), 32'd1);
        chk("bad_no_valid", 32'(rsp_valid), 32'd0);
        tick(1'b0, 16'h0000, 4'd2, 32'h0000BAD2, 1'b0);
        chk("bad_err_sticky", 32'(err_unexp), 32'd1);
        chk("bad_still_pend", 32'(rsp_valid), 32'd0);
        tick(1'b0, 16'h0000, 4'd4, 32'h44444444, 1'b0);
        chk("bad_good_cpl", rsp_data, 32'h44444444);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b1);

        // Reset with three requests in flight
        tick(1'b1, 16'h0601, 4'd0, 32'd0, 1'b0);
        tick(1'b1, 16'h0602, 4'd0, 32'd0, 1'b0);
        tick(1'b1, 16'h0603, 4'd0, 32'd0, 1'b0);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_trans", 32'(ip_req_trans), 32'd0);
        chk("mid_rst_addr", 32'(ip_addr), 32'd0);
        chk("mid_rst_err", 32'(err_unexp), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, 16'h0000, 4'd1, 32'h12345678, 1'b1);
        chk("late_cpl_err", 32'(err_unexp), 32'd1);
        chk("late_cpl_novalid", 32'(rsp_valid), 32'd0);
        tick(1'b1, 16'h0700, 4'd0, 32'd0, 1'b0);
        chk("post_rst_tag", 32'(ip_req_trans), 32'h21);
        tick(1'b0, 16'h0000, 4'd0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
